// File: rtl/bcd_stopwatch_pkg.sv
// Shared BCD types, digit limits and helpers for the two-digit stopwatch.
package bcd_stopwatch_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t units;
  } bcd_pair_t;

  typedef enum logic {
    RUN_STOPPED = 1'b0,
    RUN_ACTIVE  = 1'b1
  } run_state_e;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Out-of-range load digits clamp to 9 so the count can never hold 10..15.
  function automatic bcd_digit_t bcd_saturate(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : bcd_digit_t'(d);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single-decade BCD up/down counter with clear, saturating load and a
// combinational carry/borrow-out that is only asserted while enabled.
module bcd_digit
  import bcd_stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       dir,
  input  logic       load,
  input  bcd_digit_t load_val,
  input  logic       clear,
  output bcd_digit_t digit,
  output logic       co
);

  bcd_digit_t next_up;
  bcd_digit_t next_dn;

  // A stray non-BCD value rolls back into range on the next step.
  always_comb begin
    next_up = (digit >= BCD_MAX) ? BCD_MIN : digit + 4'd1;
    next_dn = (digit == BCD_MIN || digit > BCD_MAX) ? BCD_MAX : digit - 4'd1;
  end

  assign co = en & (dir ? (digit == BCD_MAX) : (digit == BCD_MIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= BCD_MIN;
    end else if (clear) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= bcd_saturate(load_val);
    end else if (en) begin
      digit <= dir ? next_up : next_dn;
    end
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// Two-digit BCD stopwatch: prescaler and run flag here, digits in bcd_digit.
// Priority each cycle is clear, then load, then the tick step.
module bcd_stopwatch
  import bcd_stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       up_down,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic       running,
  output logic       wrap
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] prescaler;
  run_state_e    run_state;
  bcd_pair_t     ld_pair;
  logic          tick;
  logic          step;
  logic          tens_en;
  logic          units_co;
  logic          tens_co;

  assign ld_pair = bcd_pair_t'(load_val);
  assign running = (run_state == RUN_ACTIVE);
  assign tick    = running && (prescaler == PRE_LAST);
  assign step    = tick && !clear && !load;
  assign tens_en = step && units_co;

  // The run flag is sampled before the toggle, so a stop on a tick cycle
  // still lets that tick's step complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_state <= RUN_STOPPED;
      prescaler <= '0;
      wrap      <= 1'b0;
    end else begin
      wrap <= step && tens_co;
      if (clear) begin
        run_state <= RUN_STOPPED;
        prescaler <= '0;
      end else begin
        if (start_stop) begin
          run_state <= running ? RUN_STOPPED : RUN_ACTIVE;
        end
        if (load || tick) begin
          prescaler <= '0;
        end else if (running) begin
          prescaler <= prescaler + 1'b1;
        end
      end
    end
  end

  bcd_digit u_units (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (step),
    .dir      (up_down),
    .load     (load),
    .load_val (ld_pair.units),
    .clear    (clear),
    .digit    (units),
    .co       (units_co)
  );

  bcd_digit u_tens (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tens_en),
    .dir      (up_down),
    .load     (load),
    .load_val (ld_pair.tens),
    .clear    (clear),
    .digit    (tens),
    .co       (tens_co)
  );

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Scoreboard bench for bcd_stopwatch: a decimal-count model predicts each
// cycle, a monitor compares one prediction per clock edge.
module tb_bcd_stopwatch;

  localparam int TD = 4;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
    logic       running;
    logic       wrap;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic       up_down = 1'b1;
  logic [3:0] units;
  logic [3:0] tens;
  logic       running;
  logic       wrap;

  int   errors = 0;
  int   checks = 0;
  int   wrapSeen = 0;
  obs_t expQ[$];

  int   mCount = 0;
  int   mPre = 0;
  logic mRun = 1'b0;
  logic upDown = 1'b1;

  bcd_stopwatch #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .clear      (clear),
    .load       (load),
    .load_val   (load_val),
    .up_down    (up_down),
    .units      (units),
    .tens       (tens),
    .running    (running),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  // Compare one observation against its prediction and log any difference.
  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got tens=%0d units=%0d running=%0b wrap=%0b, expected tens=%0d units=%0d running=%0b wrap=%0b",
               name, act.tens, act.units, act.running, act.wrap,
               exp.tens, exp.units, exp.running, exp.wrap);
    end
  endtask

  function automatic obs_t currentObs();
    obs_t o;
    o.tens = tens;
    o.units = units;
    o.running = running;
    o.wrap = wrap;
    return o;
  endfunction

  function automatic obs_t mkObs(input int cnt, input logic run, input logic w);
    obs_t o;
    o.tens = 4'(cnt / 10);
    o.units = 4'(cnt % 10);
    o.running = run;
    o.wrap = w;
    return o;
  endfunction

  function automatic int satDigit(input int d);
    return (d > 9) ? 9 : d;
  endfunction

  // Drive one cycle's inputs at the falling edge and predict the result.
  task automatic applyStimulus(input logic ss, input logic clr, input logic ld, input logic [7:0] lv);
    logic tick;
    logic w;
    obs_t e;
    @(negedge clk);
    start_stop = ss;
    clear = clr;
    load = ld;
    load_val = lv;
    up_down = upDown;
    tick = mRun && (mPre == TD - 1);
    w = 1'b0;
    if (clr) begin
      mCount = 0;
      mPre = 0;
      mRun = 1'b0;
    end else begin
      if (ld) begin
        mCount = satDigit(int'(lv[7:4])) * 10 + satDigit(int'(lv[3:0]));
        mPre = 0;
      end else if (tick) begin
        if (upDown) begin
          w = (mCount == 99);
          mCount = (mCount + 1) % 100;
        end else begin
          w = (mCount == 0);
          mCount = (mCount + 99) % 100;
        end
        mPre = 0;
      end else if (mRun) begin
        mPre = mPre + 1;
      end
      if (ss) mRun = ~mRun;
    end
    e = mkObs(mCount, mRun, w);
    expQ.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic expectNow(input string name, input int cnt, input logic run, input logic w);
    @(posedge clk);
    #2;
    checkOutput(name, currentObs(), mkObs(cnt, run, w));
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every edge the DUT presents a new state; pop and compare.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && expQ.size() > 0) begin
        obs_t e;
        e = expQ.pop_front();
        if (wrap) wrapSeen++;
        checkOutput("scoreboard", currentObs(), e);
      end
    end
  end

  initial begin
    int base;
    int r;
    #12;
    checkOutput("reset_state", currentObs(), mkObs(0, 1'b0, 1'b0));
    #10 rst_n = 1'b1;

    upDown = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    idle(40);
    expectNow("count_to_10", 10, 1'b1, 1'b0);
    checkCount("no_wrap_0_to_10", wrapSeen, 0);

    applyStimulus(1'b0, 1'b0, 1'b1, 8'h98);
    expectNow("load_98", 98, 1'b1, 1'b0);
    idle(4);
    expectNow("up_99", 99, 1'b1, 1'b0);
    base = wrapSeen;
    idle(4);
    expectNow("up_wrap_00", 0, 1'b1, 1'b1);
    idle(1);
    expectNow("wrap_one_cycle", 0, 1'b1, 1'b0);
    checkCount("single_up_wrap", wrapSeen - base, 1);

    upDown = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    idle(4);
    expectNow("down_wrap_99", 99, 1'b1, 1'b1);
    idle(4);
    expectNow("down_98", 98, 1'b1, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1, 8'h57);
    idle(2);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    expectNow("clear_beats_ss", 0, 1'b0, 1'b0);
    idle(20);
    expectNow("cleared_idle", 0, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1, 8'hAF);
    expectNow("load_saturate", 99, 1'b0, 1'b0);
    idle(12);
    expectNow("stopped_holds", 99, 1'b0, 1'b0);

    upDown = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h42);
    expectNow("ss_with_load", 42, 1'b1, 1'b0);
    idle(2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 checkOutput("async_reset", currentObs(), mkObs(0, 1'b0, 1'b0));
    mCount = 0;
    mPre = 0;
    mRun = 1'b0;
    base = wrapSeen;
    #20 rst_n = 1'b1;
    idle(10);
    expectNow("after_reset_idle", 0, 1'b0, 1'b0);
    checkCount("no_wrap_after_reset", wrapSeen - base, 0);

    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 9) == 0) upDown = 1'($urandom_range(0, 1));
      applyStimulus(r < 5, (r >= 5) && (r < 7), (r >= 7) && (r < 11), 8'($urandom));
    end

    @(posedge clk);
    #3;
    checkCount("scoreboard_drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
